// File: rtl/aes_sbox_pkg.sv
// Shared types and sizes for the time-multiplexed S-box controller.
// Owner encoding doubles as the round-robin "last grant" marker.
package aes_sbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        KEY = 1'b0,
        BLK = 1'b1
    } owner_t;

    localparam int BLK_BYTES  = 16;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/sbox_share_ctrl_roundsbox.sv
// Single AES forward S-box: multiplicative inverse in GF(2^8) (x^254)
// followed by the affine transform.
module roundsbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Square-and-multiply over the exponent 8'b1111_1110; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    logic [7:0] w_inv;

    assign w_inv = gf_inv(i_in);
    assign o_out = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares LANES S-boxes between key-schedule SubWord and round SubBytes,
// one transaction at a time with round-robin arbitration between requesters.
module sbox_share_ctrl
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_word,
    output logic         key_out_valid,
    input  logic         key_out_ready,
    output logic [31:0]  key_out_word,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_in,
    output logic         blk_out_valid,
    input  logic         blk_out_ready,
    output logic [127:0] blk_out,
    output logic         busy,
    output state_t       dbg_state
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
    end

    localparam logic [3:0] KEY_LAST = 4'(WORD_BYTES - LANES);
    localparam logic [3:0] BLK_LAST = 4'(BLK_BYTES - LANES);
    localparam logic [3:0] STEP     = 4'(LANES);

    state_t         r_state;
    state_t         w_state_nx;
    owner_t         r_owner;
    owner_t         r_last;
    logic [3:0]     r_cnt;
    logic [127:0]   r_work;
    logic           w_grant_key;
    logic           w_key_acc;
    logic           w_blk_acc;
    logic           w_last_step;
    logic           w_out_hs;
    logic [LANES-1:0][7:0] w_sub;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; results are held (valid and data stable) until out_ready.
    assign w_grant_key = (key_valid && !blk_valid) ||
                         ((key_valid == blk_valid) && (r_last == BLK));
    assign key_ready   = rst_n && (r_state == IDLE) && w_grant_key;
    assign blk_ready   = rst_n && (r_state == IDLE) && !w_grant_key;
    assign w_key_acc   = key_valid && key_ready;
    assign w_blk_acc   = blk_valid && blk_ready;
    assign w_last_step = (r_cnt == ((r_owner == KEY) ? KEY_LAST : BLK_LAST));

    assign key_out_valid = (r_state == DONE) && (r_owner == KEY);
    assign blk_out_valid = (r_state == DONE) && (r_owner == BLK);
    assign key_out_word  = key_out_valid ? r_work[31:0] : '0;
    assign blk_out       = blk_out_valid ? r_work : '0;
    assign w_out_hs      = (key_out_valid && key_out_ready) || (blk_out_valid && blk_out_ready);
    assign busy          = (r_state == RUN) || (r_state == DONE);
    assign dbg_state     = r_state;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_key_acc || w_blk_acc) w_state_nx = RUN;
            RUN:     if (w_last_step) w_state_nx = DONE;
            DONE:    if (w_out_hs) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [6:0] w_idx;
        assign w_idx = {r_cnt + 4'(l), 3'b000};
        roundsbox u_sbox (
            .i_in  (r_work[w_idx +: 8]),
            .o_out (w_sub[l])
        );
    end

    // Bytes are substituted in place, so the work register becomes the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_work  <= '0;
            r_owner <= KEY;
            r_last  <= BLK;
        end else if (w_key_acc || w_blk_acc) begin
            r_work  <= w_key_acc ? {96'b0, key_word} : blk_in;
            r_owner <= w_key_acc ? KEY : BLK;
            r_last  <= w_key_acc ? KEY : BLK;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                r_work[{r_cnt + 4'(l), 3'b000} +: 8] <= w_sub[l];
            end
            if (!w_last_step) r_cnt <= r_cnt + STEP;
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: three instances (LANES = 1, 2, 4) checked against
// a table-based S-box model, vector table, directed corner cases and random traffic.
module tb_sbox_share_ctrl;
    import aes_sbox_pkg::*;

    logic         clk;
    logic         rst_n         [3];
    logic         key_valid     [3];
    logic         key_ready     [3];
    logic [31:0]  key_word      [3];
    logic         key_out_valid [3];
    logic         key_out_ready [3];
    logic [31:0]  key_out_word  [3];
    logic         blk_valid     [3];
    logic         blk_ready     [3];
    logic [127:0] blk_in        [3];
    logic         blk_out_valid [3];
    logic         blk_out_ready [3];
    logic [127:0] blk_out       [3];
    logic         busy          [3];
    state_t       dbg_state     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sbox_share_ctrl #(.LANES(1 << g)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .key_valid     (key_valid[g]),
            .key_ready     (key_ready[g]),
            .key_word      (key_word[g]),
            .key_out_valid (key_out_valid[g]),
            .key_out_ready (key_out_ready[g]),
            .key_out_word  (key_out_word[g]),
            .blk_valid     (blk_valid[g]),
            .blk_ready     (blk_ready[g]),
            .blk_in        (blk_in[g]),
            .blk_out_valid (blk_out_valid[g]),
            .blk_out_ready (blk_out_ready[g]),
            .blk_out       (blk_out[g]),
            .busy          (busy[g]),
            .dbg_state     (dbg_state[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sbox_t [256];
    owner_t     m_last [3];

    int           s_k_acc, s_b_acc, s_k_fv, s_b_fv;
    logic [31:0]  s_k_res;
    logic [127:0] s_b_res;

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] sub_n(input logic [127:0] x, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = sbox_t[x[8*i +: 8]];
        return r;
    endfunction

    function automatic int lat_of(input int d, input int n);
        return n / (1 << d) + 1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Raises the requested valids together and runs until every requested result
    // has been handed over; records accept / first-valid cycles and results.
    task automatic serve(input int d, input bit want_k, input logic [31:0] kw,
                         input bit want_b, input logic [127:0] bi, input bit rnd);
        bit k_got, b_got, k_pv, b_pv, k_drop, b_drop;
        logic [31:0]  k_pd;
        logic [127:0] b_pd;
        k_got = !want_k; b_got = !want_b;
        k_pv = 0; b_pv = 0; k_drop = 0; b_drop = 0;
        k_pd = '0; b_pd = '0;
        s_k_acc = -1; s_b_acc = -1; s_k_fv = -1; s_b_fv = -1;
        s_k_res = '0; s_b_res = '0;
        key_valid[d] = want_k; key_word[d] = kw;
        blk_valid[d] = want_b; blk_in[d] = bi;
        for (int c = 0; c < 400 && !(k_got && b_got); c++) begin
            key_out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            blk_out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("ready_excl", key_ready[d] & blk_ready[d], 0);
            check("one_out_valid", key_out_valid[d] & blk_out_valid[d], 0);
            check("spurious_out", (key_out_valid[d] && !want_k) || (blk_out_valid[d] && !want_b), 0);
            if (key_valid[d] && key_ready[d]) begin s_k_acc = cyc; k_drop = 1; end
            if (blk_valid[d] && blk_ready[d]) begin s_b_acc = cyc; b_drop = 1; end
            if (key_out_valid[d] && want_k) begin
                if (s_k_fv < 0) s_k_fv = cyc;
                if (k_pv) check("key_hold", key_out_word[d], k_pd);
                if (key_out_ready[d]) begin s_k_res = key_out_word[d]; k_got = 1; k_pv = 0; end
                else begin k_pv = 1; k_pd = key_out_word[d]; end
            end
            if (blk_out_valid[d] && want_b) begin
                if (s_b_fv < 0) s_b_fv = cyc;
                if (b_pv) check("blk_hold", blk_out[d], b_pd);
                if (blk_out_ready[d]) begin s_b_res = blk_out[d]; b_got = 1; b_pv = 0; end
                else begin b_pv = 1; b_pd = blk_out[d]; end
            end
            tick();
            if (k_drop) begin key_valid[d] = 0; key_word[d] = $urandom; k_drop = 0; end
            if (b_drop) begin blk_valid[d] = 0; blk_in[d] = rand128(); b_drop = 0; end
        end
        check("serve_done", {k_got, b_got}, 2'b11);
        key_valid[d] = 0; blk_valid[d] = 0;
        key_out_ready[d] = 1; blk_out_ready[d] = 1;
    endtask

    // One transaction set checked against the reference model.
    task automatic txn(input int d, input bit want_k, input logic [31:0] kw,
                       input bit want_b, input logic [127:0] bi, input bit rnd);
        int s;
        bit key_first;
        logic [127:0] ek, eb;
        s = cyc;
        key_first = want_k && (!want_b || m_last[d] == BLK);
        serve(d, want_k, kw, want_b, bi, rnd);
        if (want_k) begin
            ek = sub_n({96'b0, kw}, WORD_BYTES);
            check("key_data", s_k_res, ek[31:0]);
            check("key_lat", s_k_fv - s_k_acc, lat_of(d, WORD_BYTES));
        end
        if (want_b) begin
            eb = sub_n(bi, BLK_BYTES);
            check("blk_data", s_b_res, eb);
            check("blk_lat", s_b_fv - s_b_acc, lat_of(d, BLK_BYTES));
        end
        if (key_first) check("first_acc_key", s_k_acc, s);
        else           check("first_acc_blk", s_b_acc, s);
        if (want_k && want_b) begin
            check("order_key_first", s_k_acc < s_b_acc, key_first);
            if (!rnd) check("second_acc", key_first ? s_b_acc : s_k_acc,
                            (key_first ? s_k_fv : s_b_fv) + 1);
            m_last[d] = key_first ? BLK : KEY;
        end else begin
            m_last[d] = want_k ? KEY : BLK;
        end
    endtask

    task automatic do_reset(input int d);
        key_valid[d] = 0; blk_valid[d] = 0;
        rst_n[d] = 0;
        tick();
        rst_n[d] = 1;
        m_last[d] = BLK;
    endtask

    task automatic midrun(input int d);
        logic [127:0] bi;
        bit seen;
        bi = rand128();
        blk_in[d] = bi; blk_valid[d] = 1;
        #1;
        check("mr_blk_ready", blk_ready[d], 1);
        tick();
        blk_valid[d] = 0; blk_in[d] = rand128();
        repeat ((d == 0) ? 7 : 1) tick();
        #1;
        check("mr_state_run", dbg_state[d], RUN);
        rst_n[d] = 0;
        tick();
        rst_n[d] = 1;
        m_last[d] = BLK;
        check("mr_busy", busy[d], 0);
        seen = 0;
        repeat (20) begin
            #1;
            if (key_out_valid[d] || blk_out_valid[d]) seen = 1;
            tick();
        end
        check("mr_no_out", seen, 0);
        txn(d, 0, 32'h0, 1, rand128(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  kw;
        logic [127:0] bi, eb, got;
        int r;

        sbox_t = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
        };

        vecs[0] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01, 5};
        vecs[1] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                          128'h76abd7fe2b670130c56f6bf27b777c63, 17};
        vecs[2] = '{1'b0, 128'h0, {16{8'h63}}, 17};
        vecs[3] = '{1'b1, 128'h0, 128'h63636363, 5};
        vecs[4] = '{1'b1, 128'hffffffff, 128'h16161616, 5};

        // Reset with both requesters asserting valid.
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 0;
            key_valid[d] = 1; blk_valid[d] = 1;
            key_word[d] = 32'hdeadbeef; blk_in[d] = rand128();
            key_out_ready[d] = 1; blk_out_ready[d] = 1;
            m_last[d] = BLK;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check("rst_key_ready", key_ready[d], 0);
            check("rst_blk_ready", blk_ready[d], 0);
            check("rst_key_out_valid", key_out_valid[d], 0);
            check("rst_blk_out_valid", blk_out_valid[d], 0);
            check("rst_key_out_word", key_out_word[d], 0);
            check("rst_blk_out", blk_out[d], 0);
            check("rst_busy", busy[d], 0);
        end
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1; key_valid[d] = 0; blk_valid[d] = 0;
        end
        tick();

        // Spec vectors on the single-lane instance.
        for (int i = 0; i < 5; i++) begin
            serve(0, vecs[i].is_key, vecs[i].din[31:0], !vecs[i].is_key, vecs[i].din, 0);
            got = vecs[i].is_key ? {96'b0, s_k_res} : s_b_res;
            check("vec_data", got, vecs[i].exp);
            check("vec_lat", vecs[i].is_key ? (s_k_fv - s_k_acc) : (s_b_fv - s_b_acc), vecs[i].lat);
            m_last[0] = vecs[i].is_key ? KEY : BLK;
        end

        // Ties: key first after reset, then blk after a key-only transaction.
        do_reset(0);
        txn(0, 1, 32'h01234567, 1, rand128(), 0);
        txn(0, 1, 32'h89abcdef, 0, 128'h0, 0);
        txn(0, 1, 32'h55aa33cc, 1, rand128(), 0);
        check("tie2_blk_first", s_b_acc < s_k_acc, 1);

        // Backpressure on a block result with a key request waiting.
        bi = rand128();
        kw = $urandom;
        eb = sub_n(bi, BLK_BYTES);
        blk_in[0] = bi; blk_valid[0] = 1; blk_out_ready[0] = 0; key_valid[0] = 0;
        #1;
        check("bp_blk_ready", blk_ready[0], 1);
        tick();
        blk_valid[0] = 0; blk_in[0] = rand128();
        key_valid[0] = 1; key_word[0] = kw;
        repeat (16) tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_valid", blk_out_valid[0], 1);
            check("bp_data", blk_out[0], eb);
            check("bp_key_ready", key_ready[0], 0);
            tick();
        end
        blk_out_ready[0] = 1;
        #1;
        check("bp_valid_at_hs", blk_out_valid[0], 1);
        tick();
        m_last[0] = BLK;
        #1;
        check("bp_key_granted", key_ready[0], 1);
        txn(0, 1, kw, 0, 128'h0, 0);

        // Reset in the middle of a block transaction, every lane count.
        for (int d = 0; d < 3; d++) midrun(d);

        // Random traffic with random consumer backpressure.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 10; i++) begin
                r = $urandom_range(1, 3);
                txn(d, r[0], $urandom, r[1], rand128(), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
